// File: rtl/rom_pkg.sv
// Shared definitions for the lookup-table loader: default geometry and FSM states.
package rom_pkg;

    localparam int unsigned ROM_ADDR_W = 3;
    localparam int unsigned ROM_DATA_W = 4;
    localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rom_loader_mem.sv
// Table storage: DEPTH x DATA_W registers, one synchronous write port,
// combinational read port, asynchronous clear to all-zero.
module rom_loader_mem
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every entry on reset; otherwise write one entry when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is purely combinational, so a same-address write shows up after the edge.
    assign data = mem[adr];

endmodule

// File: rtl/rom_loader.sv
// Loads an 8x4 lookup table from a valid/ready nibble stream and exposes the
// same combinational read port as the fixed ROM it replaces.
module rom_loader
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W:0]   wr_count,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             done_nxt, ovf_nxt, ready_nxt;
    logic             we;

    rom_loader_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_count[ADDR_W-1:0]),
        .wdata (in_data),
        .adr   (adr),
        .data  (data)
    );

    // State, pointer and flag registers; in_ready is registered so it rises the cycle after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_count <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_count <= count_nxt;
            done     <= done_nxt;
            ovf      <= ovf_nxt;
            in_ready <= ready_nxt;
        end
    end

    // Next-state logic; start outranks an overflow offer in the same cycle since it clears ovf.
    always_comb begin
        state_nxt = state;
        count_nxt = wr_count;
        done_nxt  = done;
        ovf_nxt   = ovf;
        ready_nxt = in_ready;
        we        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                    done_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    ready_nxt = 1'b1;
                end else if (in_valid) begin
                    ovf_nxt = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    we        = 1'b1;
                    count_nxt = wr_count + CNT_W'(1);
                    if (wr_count == CNT_W'(DEPTH - 1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b0;
            end
        endcase
    end

endmodule
